// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp sequencer for the PWM generator.
// Steps the live duty toward a commanded target, only on PWM period boundaries.
module pwm_ramp_ctrl #(
    parameter int         PERIODS_PER_STEP = 4,
    parameter logic [7:0] DUTY_INIT        = 8'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pwm_counter,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_target,
    input  logic [3:0] cmd_step,
    input  logic       abort,
    output logic       cmd_ready,
    output logic [7:0] duty_cycle,
    output logic       busy,
    output logic       done
);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(PERIODS_PER_STEP - 1);

    state_t     state;
    logic [7:0] target;
    logic [3:0] step;
    logic [3:0] period_cnt;

    logic       tick;
    logic       up;
    logic [8:0] diff;
    logic       close;

    assign tick  = (pwm_counter == 8'hFF);
    assign up    = (target > duty_cycle);
    assign diff  = up ? ({1'b0, target} - {1'b0, duty_cycle})
                      : ({1'b0, duty_cycle} - {1'b0, target});
    // Final step lands exactly on the target, so duty can never overshoot or wrap.
    assign close = (diff <= {5'b0, step});

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == RAMP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            duty_cycle <= DUTY_INIT;
            done       <= 1'b0;
            target     <= 8'd0;
            step       <= 4'd0;
            period_cnt <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        target     <= cmd_target;
                        step       <= (cmd_step == 4'd0) ? 4'd1 : cmd_step;
                        period_cnt <= 4'd0;
                        state      <= RAMP;
                    end
                end
                RAMP: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (period_cnt == CNT_LAST) begin
                            period_cnt <= 4'd0;
                            if (close) begin
                                duty_cycle <= target;
                                done       <= 1'b1;
                                state      <= IDLE;
                            end else if (up) begin
                                duty_cycle <= duty_cycle + {4'b0, step};
                            end else begin
                                duty_cycle <= duty_cycle - {4'b0, step};
                            end
                        end else begin
                            period_cnt <= period_cnt + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Randomized bench for pwm_ramp_ctrl against a tick-count based ramp model.
// Ticks are placed at random cycles; expected duty is derived from ticks seen.
module tb_pwm_ramp_ctrl;

    localparam int P = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pwm_counter;
    logic       cmd_valid;
    logic [7:0] cmd_target;
    logic [3:0] cmd_step;
    logic       abort;
    logic       cmd_ready;
    logic [7:0] duty_cycle;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;
    int mdl_duty = 0;

    pwm_ramp_ctrl #(
        .PERIODS_PER_STEP(P),
        .DUTY_INIT(8'd0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pwm_counter(pwm_counter),
        .cmd_valid(cmd_valid),
        .cmd_target(cmd_target),
        .cmd_step(cmd_step),
        .abort(abort),
        .cmd_ready(cmd_ready),
        .duty_cycle(duty_cycle),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // Duty after k completed updates: straight-line walk toward t, clamped at t.
    function automatic int model_duty(int d0, int t, int s, int k);
        int diff;
        diff = (t > d0) ? t - d0 : d0 - t;
        if (k * s >= diff) return t;
        return (t > d0) ? d0 + k * s : d0 - k * s;
    endfunction

    task automatic tick_cycle(input bit tk);
        pwm_counter = tk ? 8'hFF : 8'($urandom_range(0, 254));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cmd_valid = 1'b1;
        abort = 1'b1;
        tick_cycle(1'b1);
        tick_cycle(1'b1);
        cmd_valid = 1'b0;
        abort = 1'b0;
        tests++;
        if (duty_cycle !== 8'd0) begin
            fails++;
            $display("FAIL reset_duty got %0d want 0", duty_cycle);
        end
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_flags got busy=%b done=%b rdy=%b want 0 0 1",
                     busy, done, cmd_ready);
        end
        reset = 1'b0;
        mdl_duty = 0;
    endtask

    task automatic test_ramp(input int t, input int s);
        int d0, se, diff, kdone, total, ticks, guard, exp_d;
        bit tk, exp_done, exp_busy;
        d0 = mdl_duty;
        se = (s == 0) ? 1 : s;
        diff = (t > d0) ? t - d0 : d0 - t;
        kdone = (diff == 0) ? 1 : (diff + se - 1) / se;
        total = kdone * P;
        cmd_valid = 1'b1;
        cmd_target = 8'(t);
        cmd_step = 4'(s);
        tick_cycle($urandom_range(0, 1) == 1);
        cmd_valid = 1'b0;
        tests++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL accept_flags got busy=%b rdy=%b done=%b want 1 0 0",
                     busy, cmd_ready, done);
        end
        tests++;
        if (duty_cycle !== 8'(d0)) begin
            fails++;
            $display("FAIL accept_duty got %0d want %0d", duty_cycle, d0);
        end
        ticks = 0;
        guard = 0;
        while (ticks < total && guard < total * 16 + 64) begin
            tk = ($urandom_range(0, 2) == 0);
            guard++;
            cmd_valid = ($urandom_range(0, 7) == 0);
            cmd_target = 8'd99;
            cmd_step = 4'($urandom_range(0, 15));
            tick_cycle(tk);
            cmd_valid = 1'b0;
            if (tk) ticks++;
            exp_d = model_duty(d0, t, se, ticks / P);
            exp_done = tk && (ticks == total);
            exp_busy = (ticks < total);
            tests++;
            if (duty_cycle !== 8'(exp_d)) begin
                fails++;
                $display("FAIL ramp_duty %0d->%0d s=%0d tick=%0d got %0d want %0d",
                         d0, t, s, ticks, duty_cycle, exp_d);
            end
            tests++;
            if (done !== exp_done) begin
                fails++;
                $display("FAIL ramp_done tick=%0d got %b want %b",
                         ticks, done, exp_done);
            end
            tests++;
            if (busy !== exp_busy || cmd_ready !== !exp_busy) begin
                fails++;
                $display("FAIL ramp_state tick=%0d got busy=%b rdy=%b want busy=%b",
                         ticks, busy, cmd_ready, exp_busy);
            end
        end
        tests++;
        if (ticks < total) begin
            fails++;
            $display("FAIL ramp_timeout got %0d ticks want %0d", ticks, total);
        end
        mdl_duty = t;
    endtask

    task automatic test_abort;
        int ticks, guard;
        bit tk;
        test_reset();
        cmd_valid = 1'b1;
        cmd_target = 8'd200;
        cmd_step = 4'd10;
        tick_cycle(1'b0);
        cmd_valid = 1'b0;
        ticks = 0;
        guard = 0;
        while (ticks < 4 * P - 1 && guard < 400) begin
            tk = ($urandom_range(0, 1) == 1);
            guard++;
            tick_cycle(tk);
            if (tk) ticks++;
        end
        tests++;
        if (duty_cycle !== 8'd30 || busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_pre got duty=%0d busy=%b want 30 1",
                     duty_cycle, busy);
        end
        abort = 1'b1;
        tick_cycle(1'b1);
        abort = 1'b0;
        tests++;
        if (duty_cycle !== 8'd30 || done !== 1'b0) begin
            fails++;
            $display("FAIL abort_hold got duty=%0d done=%b want 30 0",
                     duty_cycle, done);
        end
        tests++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_state got rdy=%b busy=%b want 1 0",
                     cmd_ready, busy);
        end
        mdl_duty = 30;
    endtask

    task automatic test_reset_mid;
        int ticks, guard;
        bit tk;
        cmd_valid = 1'b1;
        cmd_target = 8'd200;
        cmd_step = 4'd10;
        tick_cycle(1'b0);
        cmd_valid = 1'b0;
        ticks = 0;
        guard = 0;
        while (ticks < 2 * P + 1 && guard < 400) begin
            tk = ($urandom_range(0, 1) == 1);
            guard++;
            tick_cycle(tk);
            if (tk) ticks++;
        end
        tests++;
        if (busy !== 1'b1 || duty_cycle !== 8'(mdl_duty + 20)) begin
            fails++;
            $display("FAIL rstmid_pre got duty=%0d busy=%b want %0d 1",
                     duty_cycle, busy, mdl_duty + 20);
        end
        reset = 1'b1;
        cmd_valid = 1'b1;
        abort = 1'b1;
        tick_cycle(1'b1);
        reset = 1'b0;
        cmd_valid = 1'b0;
        abort = 1'b0;
        tests++;
        if (duty_cycle !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL rstmid got duty=%0d busy=%b done=%b want 0 0 0",
                     duty_cycle, busy, done);
        end
        mdl_duty = 0;
    endtask

    task automatic test_idle_hold;
        for (int i = 0; i < 8; i++) begin
            abort = ($urandom_range(0, 1) == 1);
            tick_cycle($urandom_range(0, 1) == 1);
            tests++;
            if (duty_cycle !== 8'(mdl_duty) || busy !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL idle_hold got duty=%0d busy=%b done=%b want %0d 0 0",
                         duty_cycle, busy, done, mdl_duty);
            end
        end
        abort = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        pwm_counter = 8'd0;
        cmd_valid = 1'b0;
        cmd_target = 8'd0;
        cmd_step = 4'd0;
        abort = 1'b0;
        test_reset();
        test_ramp(10, 3);
        test_ramp(0, 4);
        test_ramp(3, 0);
        test_ramp(250, 15);
        test_ramp(255, 15);
        test_ramp(255, 7);
        test_ramp(0, 15);
        test_idle_hold();
        test_abort();
        test_ramp(50, 5);
        test_reset_mid();
        for (int i = 0; i < 6; i++) begin
            test_ramp($urandom_range(0, 255), $urandom_range(0, 15));
        end
        test_ramp(mdl_duty, $urandom_range(0, 15));
        test_idle_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
